ustore_sequencer: RTL and testbench



---
 rtl/ustore_sequencer.sv | 143 ++++++++++++++
 tb/tb_ustore_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ustore_sequencer.sv
// Writable-control-store microsequencer: registered UIR, micro-PC, next-address
// selection and a return-address stack with sticky overflow/underflow flags.
module ustore_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int WORD_W      = 64,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [7:0]        cond,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic              wcs_we,
  input  logic [ADDR_W-1:0] wcs_addr,
  input  logic [WORD_W-1:0] wcs_data,
  output logic [WORD_W-1:0] uir,
  output logic [ADDR_W-1:0] upc,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] RST_A   = ADDR_W'(RESET_ADDR);
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] N_CONT    = 3'b000;
  localparam logic [2:0] N_JUMP    = 3'b001;
  localparam logic [2:0] N_DECODE  = 3'b010;
  localparam logic [2:0] N_CBR     = 3'b011;
  localparam logic [2:0] N_CDEC    = 3'b100;
  localparam logic [2:0] N_CALL    = 3'b101;
  localparam logic [2:0] N_RET     = 3'b110;
  localparam logic [2:0] N_RESTART = 3'b111;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              primed;

  logic [2:0]        n_f;
  logic              inv_f;
  logic [2:0]        s_f;
  logic [ADDR_W-1:0] cr_f;
  logic              c;
  logic [ADDR_W-1:0] inc;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              stk_full;
  logic              stk_empty;

  logic [ADDR_W-1:0] nxt;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_unf;
  logic              advance;

  assign n_f   = uir[WORD_W-1 -: 3];
  assign inv_f = uir[WORD_W-4];
  assign s_f   = uir[WORD_W-5 -: 3];
  assign cr_f  = uir[WORD_W-8 -: ADDR_W];

  assign c         = cond[s_f] ^ inv_f;
  assign inc       = upc + ADDR_W'(1);
  assign stk_full  = (sp == SP_FULL);
  assign stk_empty = (sp == '0);
  assign push_idx  = IDX_W'(sp);
  assign pop_idx   = IDX_W'(sp - SP_W'(1));

  // Only a primed, unstalled edge executes the microinstruction in uir.
  assign advance = reset_n && !stall && primed;

  always_comb begin
    nxt     = inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (n_f)
      N_CONT:    nxt = inc;
      N_JUMP:    nxt = cr_f;
      N_DECODE:  nxt = dec_addr;
      N_CBR:     nxt = c ? cr_f : inc;
      N_CDEC:    nxt = c ? cr_f : dec_addr;
      N_CALL: begin
        nxt = cr_f;
        if (stk_full) set_ovf = 1'b1;
        else          do_push = 1'b1;
      end
      N_RET: begin
        if (stk_empty) begin
          nxt     = RST_A;
          set_unf = 1'b1;
        end else begin
          nxt    = stack[pop_idx];
          do_pop = 1'b1;
        end
      end
      N_RESTART: nxt = RST_A;
      default:   nxt = inc;
    endcase
  end

  // NOTE: the control store and stack entries carry no reset; only the pointers
  // and flags that give them meaning are cleared, which keeps them plain RAM.
  always_ff @(posedge clk) begin
    if (reset_n && wcs_we) mem[wcs_addr] <= wcs_data;
  end

  always_ff @(posedge clk) begin
    if (advance && do_push) stack[push_idx] <= inc;
  end

  // uir samples mem[nxt] before this edge's write lands, giving read-first
  // behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      upc     <= RST_A;
      uir     <= '0;
      sp      <= '0;
      primed  <= 1'b0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (!stall) begin
      if (!primed) begin
        uir    <= mem[RST_A];
        primed <= 1'b1;
      end else begin
        upc <= nxt;
        uir <= mem[nxt];
        if (do_push) sp <= sp + SP_W'(1);
        if (do_pop)  sp <= sp - SP_W'(1);
        if (set_ovf) stk_ovf <= 1'b1;
        if (set_unf) stk_unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ustore_sequencer.sv
// Self-checking bench for ustore_sequencer: directed scenarios plus a random run,
// all checked against a queue-based behavioural model of the sequencer.
module tb_ustore_sequencer;

  localparam int AW = 8;
  localparam int WW = 64;
  localparam int SD = 4;
  localparam logic [AW-1:0] RST = 8'h00;

  localparam logic [2:0] CONT = 3'd0, JUMP = 3'd1, DECODE = 3'd2, CBR = 3'd3;
  localparam logic [2:0] CDEC = 3'd4, CALL = 3'd5, RET = 3'd6, RESTART = 3'd7;

  logic          clk;
  logic          reset_n;
  logic          stall;
  logic [7:0]    cond;
  logic [AW-1:0] dec_addr;
  logic          wcs_we;
  logic [AW-1:0] wcs_addr;
  logic [WW-1:0] wcs_data;
  logic [WW-1:0] uir;
  logic [AW-1:0] upc;
  logic          stk_ovf;
  logic          stk_unf;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [WW-1:0] m_mem [256];
  logic [AW-1:0] m_stk [$];
  logic [WW-1:0] m_uir;
  logic [AW-1:0] m_upc;
  logic          m_primed;
  logic          m_ovf;
  logic          m_unf;

  ustore_sequencer #(.ADDR_W(AW), .WORD_W(WW), .STACK_DEPTH(SD), .RESET_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .cond(cond), .dec_addr(dec_addr),
    .wcs_we(wcs_we), .wcs_addr(wcs_addr), .wcs_data(wcs_data),
    .uir(uir), .upc(upc), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WW-1:0] mk(input logic [2:0] n, input logic inv,
                                       input logic [2:0] s, input logic [AW-1:0] cr);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {n, inv, s, cr, r[48:0]};
  endfunction

  // Next microaddress as the sequencing rules describe it; updates model stack/flags.
  task automatic model_next(output logic [AW-1:0] nxt);
    logic [2:0]    n;
    logic          c;
    logic [AW-1:0] cr;
    logic [AW-1:0] inc;
    n   = m_uir[63:61];
    c   = cond[m_uir[59:57]] ^ m_uir[60];
    cr  = m_uir[56:49];
    inc = AW'((int'(m_upc) + 1) % 256);
    case (n)
      CONT:    nxt = inc;
      JUMP:    nxt = cr;
      DECODE:  nxt = dec_addr;
      CBR:     nxt = c ? cr : inc;
      CDEC:    nxt = c ? cr : dec_addr;
      CALL: begin
        if (m_stk.size() == SD) m_ovf = 1'b1;
        else m_stk.push_back(inc);
        nxt = cr;
      end
      RET: begin
        if (m_stk.size() == 0) begin
          m_unf = 1'b1;
          nxt   = RST;
        end else nxt = m_stk.pop_back();
      end
      default: nxt = RST;
    endcase
  endtask

  task automatic model_edge();
    logic [AW-1:0] nxt;
    if (!reset_n) begin
      m_upc = RST; m_uir = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_primed = 1'b0;
      return;
    end
    if (!stall) begin
      if (!m_primed) begin
        m_uir    = m_mem[RST];
        m_primed = 1'b1;
      end else begin
        model_next(nxt);
        m_uir = m_mem[nxt];
        m_upc = nxt;
      end
    end
    if (wcs_we) m_mem[wcs_addr] = wcs_data;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
    wcs_we = 1'b1; wcs_addr = a; wcs_data = d; stall = 1'b1;
    step();
    wcs_we = 1'b0; stall = 1'b0;
  endtask

  // Reach address a: restart through a JUMP planted at the reset address.
  task automatic goto_addr(input logic [AW-1:0] a);
    wr(RST, mk(JUMP, 1'b0, 3'd0, a));
    reset_n = 1'b0; step();
    reset_n = 1'b1; step();
    step();
  endtask

  task automatic test_reset();
    logic [WW-1:0] word_a;
    for (int i = 0; i < 256; i++) wr(AW'(i), mk(CONT, 1'($urandom), 3'($urandom), 8'($urandom)));
    word_a = mk(CONT, 1'b1, 3'd5, 8'h99);
    wr(8'h00, word_a);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (upc !== RST) begin n_fail++; $display("FAIL reset_upc: got %h want %h", upc, RST); end
      n_checks++; if (uir !== '0) begin n_fail++; $display("FAIL reset_uir: got %h want 0", uir); end
      n_checks++; if ({stk_ovf, stk_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {stk_ovf, stk_unf}); end
    end
    reset_n = 1'b1;
    step();
    n_checks++; if (upc !== 8'h00 || uir !== word_a) begin n_fail++; $display("FAIL prime_edge: upc=%h uir=%h want 00 %h", upc, uir, word_a); end
    step();
    n_checks++; if (upc !== 8'h01 || uir !== m_mem[1]) begin n_fail++; $display("FAIL first_exec: upc=%h uir=%h want 01 %h", upc, uir, m_mem[1]); end
  endtask

  task automatic test_branch();
    logic [AW-1:0] exp;
    logic          inv;
    logic [2:0]    s;
    logic [AW-1:0] cr;
    for (int k = 0; k < 4; k++) begin
      inv = 1'(k >> 1);
      wr(8'h05, mk(CBR, inv, 3'd3, 8'h40));
      goto_addr(8'h05);
      cond = 8'($urandom);
      cond[3] = 1'(k & 1);
      exp = (cond[3] ^ inv) ? 8'h40 : 8'h06;
      step();
      n_checks++; if (upc !== exp) begin n_fail++; $display("FAIL cbr_dir%0d: upc=%h want %h", k, upc, exp); end
    end
    for (int k = 0; k < 8; k++) begin
      inv = 1'($urandom); s = 3'($urandom); cr = 8'($urandom);
      wr(8'h05, mk(CBR, inv, s, cr));
      goto_addr(8'h05);
      cond = 8'($urandom);
      exp = (cond[s] ^ inv) ? cr : 8'h06;
      step();
      n_checks++; if (upc !== exp || uir !== m_mem[exp]) begin n_fail++; $display("FAIL cbr_rand%0d: upc=%h uir=%h want %h %h", k, upc, uir, exp, m_mem[exp]); end
    end
  endtask

  task automatic test_decode();
    wr(8'h01, mk(DECODE, 1'b0, 3'd0, 8'h00));
    wr(8'h2A, mk(CDEC, 1'b1, 3'd2, 8'h55));
    goto_addr(8'h01);
    dec_addr = 8'h2A;
    step();
    n_checks++; if (upc !== 8'h2A) begin n_fail++; $display("FAIL decode: upc=%h want 2a", upc); end
    cond = 8'($urandom) | 8'h04;
    dec_addr = 8'h10;
    step();
    n_checks++; if (upc !== 8'h10) begin n_fail++; $display("FAIL cdec_fall: upc=%h want 10", upc); end
    goto_addr(8'h2A);
    cond = 8'($urandom) & 8'hFB;
    step();
    n_checks++; if (upc !== 8'h55) begin n_fail++; $display("FAIL cdec_taken: upc=%h want 55", upc); end
  endtask

  task automatic test_nest();
    logic [AW-1:0] path [8];
    path = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hB1, 8'hA1, 8'h91, 8'h81};
    wr(8'h80, mk(CALL, 1'b0, 3'd0, 8'h90));
    wr(8'h90, mk(CALL, 1'b0, 3'd0, 8'hA0));
    wr(8'hA0, mk(CALL, 1'b0, 3'd0, 8'hB0));
    wr(8'hB0, mk(CALL, 1'b0, 3'd0, 8'hC0));
    wr(8'hC0, mk(RET,  1'b0, 3'd0, 8'h00));
    wr(8'hB1, mk(RET,  1'b0, 3'd0, 8'h00));
    wr(8'hA1, mk(RET,  1'b0, 3'd0, 8'h00));
    wr(8'h91, mk(RET,  1'b0, 3'd0, 8'h00));
    wr(8'h81, mk(CONT, 1'b0, 3'd0, 8'h00));
    goto_addr(8'h80);
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (upc !== path[i] || {stk_ovf, stk_unf} !== 2'b00) begin
        n_fail++; $display("FAIL nest_%0d: upc=%h flags=%b want %h 00", i, upc, {stk_ovf, stk_unf}, path[i]);
      end
    end
    wr(8'hC0, mk(CALL, 1'b0, 3'd0, 8'hD0));
    goto_addr(8'h80);
    for (int i = 0; i < 4; i++) step();
    step();
    n_checks++; if (upc !== 8'hD0 || stk_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow: upc=%h ovf=%b want d0 1", upc, stk_ovf); end
    step();
    n_checks++; if (stk_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: ovf=%b want 1", stk_ovf); end
    wr(8'h30, mk(RET, 1'b0, 3'd0, 8'h00));
    goto_addr(8'h30);
    n_checks++; if (stk_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", stk_ovf); end
    step();
    n_checks++; if (upc !== RST || stk_unf !== 1'b1) begin n_fail++; $display("FAIL underflow: upc=%h unf=%b want 00 1", upc, stk_unf); end
  endtask

  task automatic test_stall_wrap();
    logic [WW-1:0] held;
    wr(8'hFF, mk(CONT, 1'b0, 3'd0, 8'h00));
    goto_addr(8'hFF);
    held = m_mem[8'hFF];
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; cond = 8'($urandom); dec_addr = 8'($urandom);
      step();
      n_checks++; if (upc !== 8'hFF || uir !== held) begin n_fail++; $display("FAIL stall_%0d: upc=%h uir=%h want ff %h", i, upc, uir, held); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (upc !== 8'h00 || uir !== m_mem[0]) begin n_fail++; $display("FAIL wrap: upc=%h uir=%h want 00 %h", upc, uir, m_mem[0]); end
  endtask

  task automatic test_collision();
    logic [WW-1:0] old_w;
    logic [WW-1:0] new_w;
    wr(8'h06, mk(CONT, 1'b0, 3'd0, 8'h00));
    wr(8'h07, mk(CONT, 1'b0, 3'd1, 8'h11));
    goto_addr(8'h06);
    old_w = m_mem[7];
    new_w = mk(CONT, 1'b1, 3'd6, 8'h22);
    wcs_we = 1'b1; wcs_addr = 8'h07; wcs_data = new_w;
    step();
    wcs_we = 1'b0;
    n_checks++; if (upc !== 8'h07 || uir !== old_w) begin n_fail++; $display("FAIL collide_old: upc=%h uir=%h want 07 %h", upc, uir, old_w); end
    wr(8'h20, mk(JUMP, 1'b0, 3'd0, 8'h07));
    goto_addr(8'h20);
    step();
    n_checks++; if (upc !== 8'h07 || uir !== new_w) begin n_fail++; $display("FAIL collide_new: upc=%h uir=%h want 07 %h", upc, uir, new_w); end
  endtask

  task automatic test_reset_call();
    goto_addr(8'h80);
    step();
    reset_n = 1'b0;
    step();
    n_checks++; if (upc !== RST || uir !== '0 || {stk_ovf, stk_unf} !== 2'b00) begin
      n_fail++; $display("FAIL reset_call: upc=%h uir=%h flags=%b want 00 0 00", upc, uir, {stk_ovf, stk_unf});
    end
    reset_n = 1'b1;
    wr(RST, mk(RET, 1'b0, 3'd0, 8'h00));
    step();
    step();
    n_checks++; if (upc !== RST || stk_unf !== 1'b1) begin n_fail++; $display("FAIL reset_call_stack: upc=%h unf=%b want 00 1", upc, stk_unf); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) wr(AW'(i), {$urandom(), $urandom()});
    reset_n = 1'b0; step(); reset_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      stall    = ($urandom_range(0, 4) == 0);
      cond     = 8'($urandom);
      dec_addr = 8'($urandom);
      wcs_we   = ($urandom_range(0, 5) == 0);
      wcs_addr = 8'($urandom);
      wcs_data = {$urandom(), $urandom()};
      reset_n  = ($urandom_range(0, 60) != 0);
      step();
      n_checks++; if (upc !== m_upc || uir !== m_uir) begin n_fail++; $display("FAIL rand_%0d: upc=%h uir=%h want %h %h", i, upc, uir, m_upc, m_uir); end
      n_checks++; if (stk_ovf !== m_ovf || stk_unf !== m_unf) begin n_fail++; $display("FAIL rand_flags_%0d: got %b%b want %b%b", i, stk_ovf, stk_unf, m_ovf, m_unf); end
    end
    wcs_we = 1'b0; stall = 1'b0; reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; stall = 1'b0; cond = '0; dec_addr = '0;
    wcs_we = 1'b0; wcs_addr = '0; wcs_data = '0;
    m_uir = '0; m_upc = '0; m_primed = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_branch();
    test_decode();
    test_nest();
    test_stall_wrap();
    test_collision();
    test_reset_call();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
